// File: rtl/sar_adc_scan_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sar_adc_ctrl_pkg
// Shared types and helpers for the SAR ADC scan arbiter and its reusable
// round-robin grant logic.
//   - FSM state constants (3-bit encoding)
//   - default channel count / result width
//   - rr_pick(): first set request at or after a pointer, searching upward
//     with wrap, over up to RR_MAX_CH channels
// ---------------------------------------------------------------------------
package sar_adc_ctrl_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_N_BITS = 10;

    // rr_pick works on a fixed maximum width so one function serves every
    // instance; callers zero-extend their request vector and pointer.
    localparam int RR_MAX_CH = 16;
    localparam int RR_IDX_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_CONVERT = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_RECOVER = 3'd4;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_grant_t;

    typedef logic [RR_IDX_W:0] rr_sum_t;

    // Candidates are visited from farthest to nearest so the nearest set
    // request (relative to ptr) is the last one written and wins.
    function automatic rr_grant_t rr_pick(input logic [RR_MAX_CH-1:0] req,
                                          input logic [RR_IDX_W-1:0]  ptr,
                                          input int                   n);
        rr_grant_t g;
        rr_sum_t   c;
        g = '0;
        for (int i = RR_MAX_CH - 1; i >= 0; i--) begin
            if (i < n) begin
                c = {1'b0, ptr} + rr_sum_t'(i);
                if (c >= rr_sum_t'(n)) begin
                    c = c - rr_sum_t'(n);
                end
                if (req[c[RR_IDX_W-1:0]]) begin
                    g.valid = 1'b1;
                    g.idx   = c[RR_IDX_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sar_adc_scan_arbiter_if.sv
// ---------------------------------------------------------------------------
// sar_adc_scan_arbiter_if
// Bundles the requester-side handshake and the ADC-side handshake of the
// scan arbiter.
//   slave  : arbiter view (inputs req/eoc/result, outputs ack/result/mux/hold)
//   master : environment view (requesters + ADC), directions mirrored
// Signals:
//   req_digital        N_CH   per-channel level request
//   ack_digital        N_CH   one-hot completion pulse
//   result_digital     N_BITS conversion result during ack
//   result_channel     CH_W   channel index during ack
//   err_timeout        1      conversion aborted (result forced 0)
//   busy               1      arbiter not idle
//   mux_sel_digital    CH_W   analog mux select
//   adc_hold_digital   1      ADC sample/hold control
//   adc_eoc            1      ADC end of conversion
//   adc_result_digital N_BITS ADC output word
// ---------------------------------------------------------------------------
interface sar_adc_scan_arbiter_if
    import sar_adc_ctrl_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int N_BITS = DEF_N_BITS
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   req_digital;
    logic [N_CH-1:0]   ack_digital;
    logic [N_BITS-1:0] result_digital;
    logic [CH_W-1:0]   result_channel;
    logic              err_timeout;
    logic              busy;
    logic [CH_W-1:0]   mux_sel_digital;
    logic              adc_hold_digital;
    logic              adc_eoc;
    logic [N_BITS-1:0] adc_result_digital;

    modport slave (
        input  req_digital,
        input  adc_eoc,
        input  adc_result_digital,
        output ack_digital,
        output result_digital,
        output result_channel,
        output err_timeout,
        output busy,
        output mux_sel_digital,
        output adc_hold_digital
    );

    modport master (
        output req_digital,
        output adc_eoc,
        output adc_result_digital,
        input  ack_digital,
        input  result_digital,
        input  result_channel,
        input  err_timeout,
        input  busy,
        input  mux_sel_digital,
        input  adc_hold_digital
    );

endinterface

// File: rtl/sar_adc_scan_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sar_rr_arbiter
// Purely combinational round-robin next-grant: first set bit of i_req at or
// after i_ptr, searching upward with wrap.
//   i_req   N_CH  request vector
//   i_ptr   CH_W  search start (0..N_CH-1)
//   o_valid 1     any request set
//   o_idx   CH_W  granted channel index (0 when o_valid = 0)
// ---------------------------------------------------------------------------
module sar_rr_arbiter
    import sar_adc_ctrl_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
) (
    input  logic [N_CH-1:0]         i_req,
    input  logic [$clog2(N_CH)-1:0] i_ptr,
    output logic                    o_valid,
    output logic [$clog2(N_CH)-1:0] o_idx
);
    localparam int CH_W = $clog2(N_CH);

    logic [RR_MAX_CH-1:0] w_req_ext;
    logic [RR_IDX_W-1:0]  w_ptr_ext;
    rr_grant_t            w_pick;
    logic                 w_unused_idx;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_CH-1:0]    = i_req;
        w_ptr_ext              = '0;
        w_ptr_ext[CH_W-1:0]    = i_ptr;
        w_pick                 = rr_pick(w_req_ext, w_ptr_ext, N_CH);
    end

    assign o_valid      = w_pick.valid;
    assign o_idx        = w_pick.idx[CH_W-1:0];
    // Upper index bits are always zero for N_CH < RR_MAX_CH.
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/sar_adc_scan_arbiter.sv
// ---------------------------------------------------------------------------
// sar_adc_scan_arbiter
// Shares one SAR ADC between N_CH requesters behind an analog mux: picks a
// channel round-robin, drives the mux, waits for settling, runs the
// hold/eoc handshake and returns a tagged result (or timeout) to the winner.
// Ports:
//   clk    single clock, shared with the ADC
//   reset  asynchronous active-low reset
//   bus    sar_adc_scan_arbiter_if.slave (request/ack and ADC handshake)
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | wait for any request, register grant into mux/ch_q
//   SETTLE   | mux held stable, down-counter from SETTLE_CYCLES-1 to 0
//   CONVERT  | hold high, wait for fresh eoc edge or timeout
//   DONE     | one-cycle ack/result to ch_q, advance rr pointer
//   RECOVER  | hold low, wait for eoc to drop before re-arbitrating
// ---------------------------------------------------------------------------
module sar_adc_scan_arbiter
    import sar_adc_ctrl_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int N_BITS         = DEF_N_BITS,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    sar_adc_scan_arbiter_if.slave  bus
);
    localparam int CH_W        = $clog2(N_CH);
    localparam int TO_W        = $clog2(TIMEOUT_CYCLES);
    localparam int SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_mux_sel;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_eoc_q;
    logic              r_timeout;
    logic              r_req_lost;
    logic [N_BITS-1:0] r_result;

    logic              w_gnt_valid;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_eoc_edge;
    logic              w_to_hit;
    logic              w_req_cur;
    logic              w_ack_en;
    logic [N_CH-1:0]   w_ack;

    sar_rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr (
        .i_req   (bus.req_digital),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    // eoc_q tracks eoc in every state, so an eoc already high when CONVERT
    // is entered never looks like an edge.
    assign w_eoc_edge = bus.adc_eoc & ~r_eoc_q;
    assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_req_cur  = bus.req_digital[r_ch];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_rr_ptr     <= '0;
            r_mux_sel    <= '0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_eoc_q      <= 1'b0;
            r_timeout    <= 1'b0;
            r_req_lost   <= 1'b0;
            r_result     <= '0;
        end else begin
            r_eoc_q <= bus.adc_eoc;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_ch         <= w_gnt_idx;
                        r_mux_sel    <= w_gnt_idx;
                        r_req_lost   <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_result     <= '0;
                        r_to_cnt     <= '0;
                        r_settle_cnt <= SET_W'(SETTLE_LOAD);
                        r_state      <= (SETTLE_CYCLES == 0) ? ST_CONVERT : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!w_req_cur) begin
                        r_req_lost <= 1'b1;
                    end
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_CONVERT;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (!w_req_cur) begin
                        r_req_lost <= 1'b1;
                    end
                    // A real edge beats a simultaneous timeout.
                    if (w_eoc_edge) begin
                        r_result <= bus.adc_result_digital;
                        r_state  <= ST_DONE;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_result  <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Pointer advances even when the ack is suppressed.
                    r_rr_ptr <= (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;
                    r_state  <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (!bus.adc_eoc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ack_en = (r_state == ST_DONE) & ~r_req_lost;

    always_comb begin
        w_ack = '0;
        if (w_ack_en) begin
            w_ack[r_ch] = 1'b1;
        end
    end

    assign bus.ack_digital      = w_ack;
    assign bus.result_digital   = w_ack_en ? r_result : '0;
    assign bus.result_channel   = w_ack_en ? r_ch : '0;
    assign bus.err_timeout      = w_ack_en & r_timeout;
    assign bus.busy             = (r_state != ST_IDLE);
    assign bus.mux_sel_digital  = r_mux_sel;
    assign bus.adc_hold_digital = (r_state == ST_CONVERT);

endmodule

// File: tb/tb_sar_adc_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_scan_arbiter
// Scoreboard bench: each granted request pushes its expected channel/result/
// error; the negedge monitor pops and compares on every ack pulse. A small
// ADC model raises eoc a fixed number of cycles after hold rises.
// ---------------------------------------------------------------------------
module tb_sar_adc_scan_arbiter;
    import sar_adc_ctrl_pkg::*;

    localparam int N_CH   = 4;
    localparam int N_BITS = 10;

    logic clk;
    logic rst_n;

    sar_adc_scan_arbiter_if #(.N_CH(N_CH), .N_BITS(N_BITS)) bus ();

    sar_adc_scan_arbiter #(
        .N_CH           (N_CH),
        .N_BITS         (N_BITS),
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int res;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    int   ack_count;
    int   last_ack_cyc;
    int   hold_total;

    // ADC model / manual drive selection
    bit                adc_auto;
    int                adc_e;
    int                adc_cnt;
    logic              m_eoc;
    logic [N_BITS-1:0] m_res;
    logic              man_eoc;
    logic [N_BITS-1:0] man_res;

    assign bus.adc_eoc            = adc_auto ? m_eoc : man_eoc;
    assign bus.adc_result_digital = adc_auto ? m_res : man_res;

    function automatic int mval(input int ch);
        return 500 + 120 * ch;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.adc_hold_digital) begin
            adc_cnt <= adc_cnt + 1;
            if (adc_cnt + 1 == adc_e) begin
                m_eoc <= 1'b1;
                m_res <= N_BITS'(mval(int'(bus.mux_sel_digital)));
            end
        end else begin
            adc_cnt <= 0;
            m_eoc   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.adc_hold_digital) hold_total++;
        if (bus.ack_digital != '0) begin
            ack_count++;
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(bus.ack_digital), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_onehot", 32'(bus.ack_digital), 32'd1 << e.ch);
                chk("result_channel", 32'(bus.result_channel), 32'(e.ch));
                chk("result_digital", 32'(bus.result_digital), 32'(e.res));
                chk("err_timeout", 32'(bus.err_timeout), 32'(e.err));
            end
        end
    end

    task automatic push_exp(input int ch, input int res, input bit err);
        exp_t e;
        e.ch  = ch;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int maxc, input string tag);
        int start;
        int i;
        start = ack_count;
        i = 0;
        while (ack_count == start && i < maxc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(tag, 32'(ack_count - start), 32'd1);
    endtask

    task automatic wait_hold(input int maxc, input string tag);
        int i;
        i = 0;
        while (!bus.adc_hold_digital && i < maxc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(tag, 32'(bus.adc_hold_digital), 32'd1);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int i;
        i = 0;
        while (bus.busy && i < maxc) begin
            @(negedge clk); #1;
            i++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc_req;
        int snap;

        n_vec = 0; n_err = 0; cyc = 0; ack_count = 0; hold_total = 0;
        adc_auto = 1'b1; adc_e = 20; adc_cnt = 0; m_eoc = 1'b0; m_res = '0;
        man_eoc = 1'b0; man_res = '0;
        bus.req_digital = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hold", 32'(bus.adc_hold_digital), 32'd0);
        chk("rst_ack", 32'(bus.ack_digital), 32'd0);
        chk("rst_mux", 32'(bus.mux_sel_digital), 32'd0);
        chk("rst_result", 32'(bus.result_digital), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;

        // single request, ADC answers 20 cycles after hold
        bus.req_digital = 4'b0010;
        push_exp(1, mval(1), 1'b0);
        @(posedge clk); #1;
        cyc_req = cyc;
        chk("single_mux", 32'(bus.mux_sel_digital), 32'd1);
        @(posedge clk); #1;
        chk("single_hold_settle", 32'(bus.adc_hold_digital), 32'd0);
        @(posedge clk); #1;
        chk("single_hold_rise", 32'(bus.adc_hold_digital), 32'd1);
        wait_ack(100, "single_ack_seen");
        chk("single_latency", 32'(last_ack_cyc - cyc_req), 32'd23);
        bus.req_digital = '0;
        wait_idle(20, "single_idle");

        // fairness from a fresh pointer
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        adc_e = 6;
        for (int k = 0; k < 5; k++) push_exp(k % 4, mval(k % 4), 1'b0);
        bus.req_digital = 4'b1111;
        for (int k = 0; k < 5; k++) wait_ack(60, "fair_ack_seen");
        bus.req_digital = '0;
        wait_idle(20, "fair_idle");

        // timeout: eoc tied low (pointer now 1, only ch0 requests)
        adc_auto = 1'b0;
        man_eoc  = 1'b0;
        man_res  = 10'h2AA;
        snap = hold_total;
        bus.req_digital = 4'b0001;
        push_exp(0, 0, 1'b1);
        wait_ack(120, "timeout_ack_seen");
        chk("timeout_hold_cycles", 32'(hold_total - snap), 32'd64);
        chk("timeout_hold_low", 32'(bus.adc_hold_digital), 32'd0);
        bus.req_digital = '0;
        @(negedge clk); #1;
        chk("timeout_hold_low_next", 32'(bus.adc_hold_digital), 32'd0);
        wait_idle(20, "timeout_idle");

        // stale eoc high on entry, falls, rises 5 cycles later
        man_eoc = 1'b1;
        man_res = 10'h3FF;
        bus.req_digital = 4'b0100;
        push_exp(2, 10'h155, 1'b0);
        wait_hold(20, "stale_hold_seen");
        repeat (3) @(negedge clk);
        man_eoc = 1'b0;
        repeat (5) @(negedge clk);
        man_res = 10'h155;
        man_eoc = 1'b1;
        wait_ack(20, "stale_ack_seen");
        bus.req_digital = '0;
        repeat (3) @(negedge clk);
        chk("recover_waits_eoc", 32'(bus.busy), 32'd1);
        man_eoc = 1'b0;
        repeat (2) @(negedge clk);
        chk("recover_to_idle", 32'(bus.busy), 32'd0);

        // dropped request: ch2 granted from pointer 3, then released
        adc_auto = 1'b1;
        adc_e = 10;
        snap = ack_count;
        bus.req_digital = 4'b0100;
        wait_hold(20, "drop_hold_seen");
        chk("drop_mux", 32'(bus.mux_sel_digital), 32'd2);
        repeat (3) @(negedge clk);
        bus.req_digital = '0;
        wait_idle(60, "drop_idle");
        chk("drop_no_ack", 32'(ack_count - snap), 32'd0);
        bus.req_digital = 4'b1100;
        push_exp(3, mval(3), 1'b0);
        wait_ack(60, "drop_next_ack_seen");
        bus.req_digital = '0;
        wait_idle(20, "drop_next_idle");

        // async reset mid-conversion; pointer is first moved off 0
        bus.req_digital = 4'b0001;
        push_exp(0, mval(0), 1'b0);
        wait_ack(60, "pre_reset_ack_seen");
        bus.req_digital = '0;
        wait_idle(20, "pre_reset_idle");
        adc_e = 30;
        bus.req_digital = 4'b1001;
        wait_hold(20, "areset_hold_seen");
        chk("areset_mux_before", 32'(bus.mux_sel_digital), 32'd3);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_hold", 32'(bus.adc_hold_digital), 32'd0);
        chk("areset_busy", 32'(bus.busy), 32'd0);
        chk("areset_ack", 32'(bus.ack_digital), 32'd0);
        push_exp(0, mval(0), 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(100, "areset_regrant_ack_seen");
        bus.req_digital = '0;
        wait_idle(20, "areset_idle");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_adc_scan_arbiter.md
Name: sar_adc_scan_arbiter

Overview:
Shares one sar_adc__N_BITS_10 instance between N_CH requesters (analog channels behind an external mux).
- Arbitrates requests round-robin and drives the mux select.
- Allows analog settling, then sequences the ADC hold/eoc handshake.
- Returns the tagged result, or a timeout error, to the winning requester.
- Sits between the channel-request logic and the ADC, in the ADC's clk domain.

Parameters:
N_CH, 4, number of requesting channels (2..16)
N_BITS, 10, ADC result width
SETTLE_CYCLES, 2, cycles mux_sel_digital is held stable before hold asserts (0 = no settle state)
TIMEOUT_CYCLES, 64, max cycles in CONVERT waiting for eoc before abort (>=4)
CH_W, $clog2(N_CH), derived localparam; not overridable

Ports:
clk  input  1  single clock, shared with ADC
reset  input  1  asynchronous, active-low (0 = reset asserted)
req_digital  input  N_CH  per-channel conversion request, level, held until ack
ack_digital  output  N_CH  one-hot, one-cycle pulse to the serviced channel
result_digital  output  N_BITS  result, valid while any ack_digital bit is high
result_channel  output  CH_W  channel index of current ack
err_timeout  output  1  high with ack when conversion aborted; result_digital = 0 then
busy  output  1  high in every state except IDLE
mux_sel_digital  output  CH_W  analog mux select
adc_hold_digital  output  1  drives ADC input_hold_digital
adc_eoc  input  1  ADC eoc
adc_result_digital  input  N_BITS  ADC output_result_digital

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0, state IDLE, rr pointer 0, eoc_q 0. Reset mid-conversion drops hold immediately. No ack is issued for the aborted request.
- States: IDLE, SETTLE, CONVERT, DONE, RECOVER. Encoding is in the package.
- IDLE:
  - If any req_digital bit is set, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - Register grant index into mux_sel_digital and ch_q.
  - Go to SETTLE, or to CONVERT if SETTLE_CYCLES = 0.
  - With no request, stay in IDLE. mux_sel_digital holds its last value.
- SETTLE: down-counter loaded with SETTLE_CYCLES-1. Go to CONVERT when it reaches 0. hold stays low.
- CONVERT:
  - adc_hold_digital = 1 for every cycle in this state.
  - Timeout counter starts at 0 and increments each cycle.
  - eoc edge = adc_eoc & ~eoc_q, where eoc_q is adc_eoc registered every cycle.
  - An eoc already high on entry is stale. Only a rising edge seen while in CONVERT counts.
  - On edge: latch adc_result_digital, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge: set the timeout flag, result 0, go to DONE.
  - Edge and timeout in the same cycle: the edge wins, no error.
- DONE (exactly 1 cycle):
  - ack_digital[ch_q] = 1, result_channel = ch_q, result_digital = latched value, err_timeout = flag.
  - hold = 0. rr_ptr <= (ch_q+1) mod N_CH.
  - If req_digital[ch_q] dropped during SETTLE/CONVERT: suppress the ack (all ack bits 0). rr_ptr still advances.
- RECOVER:
  - hold = 0, held for a minimum of 1 cycle.
  - Stay until adc_eoc = 0, then go to IDLE.
  - A new grant can therefore occur at the earliest 2 cycles after DONE.
- Latency, ADC responding in E cycles after hold rises: req seen in IDLE at cycle t → hold rises at t+1+SETTLE_CYCLES → ack at t+2+SETTLE_CYCLES+E.
- Requester holding req after ack: re-arbitrated normally. A fair turn is guaranteed to all others first.
- Requests arriving during a conversion are not lost; they are served in round-robin order later.
- Result/ack outputs are 0 in every non-DONE cycle.
- All counters saturate-free: the state machine reloads them on each state entry.

Decomposition:
- Package sar_adc_ctrl_pkg:
  - state enum (IDLE, SETTLE, CONVERT, DONE, RECOVER)
  - default N_BITS / N_CH constants
  - function rr_pick(req, ptr) returning grant index + valid
- One sub-module: sar_rr_arbiter (N_CH), purely combinational next-grant from req_digital and rr_ptr.
  - Reused later for the DAC scheduler.
- Top holds the FSM, counters, eoc edge detect and output registers.

Test Plan:
- Single request: req_digital=4'b0010, ADC model eoc 20 cycles after hold.
  - → mux_sel=1, hold rises 3 cycles after req sampled (SETTLE_CYCLES=2).
  - → ack_digital=4'b0010, result_channel=1, result_digital=model value (e.g. 10'd620), err_timeout=0.
- Fairness: req_digital=4'b1111 held constant.
  - → grant order 0,1,2,3,0.
  - → each ack one-hot, exactly one per conversion, no channel served twice before all others.
- Timeout: eoc tied 0, TIMEOUT_CYCLES=64.
  - → hold high exactly 64 cycles, then ack with err_timeout=1, result_digital=0, hold low next cycle.
- Stale eoc: adc_eoc held high entering CONVERT, falls, then rises 5 cycles later.
  - → result captured only on the later rise.
  - → RECOVER waits until eoc=0 before IDLE.
- Dropped request: req_digital[2] deasserted mid-CONVERT.
  - → conversion completes, ack_digital stays 0, rr_ptr=3, next grant is channel 3 when req=4'b1100.
- Async reset: reset driven 0 mid-CONVERT.
  - → adc_hold_digital, busy, ack_digital all 0 in the same cycle (no clock edge needed).
  - → after release, pending req re-granted starting from channel 0.
